// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: walks a program from start_pc, presents
// one registered instruction per cycle over a valid/ready slot.
module fetch_seq #(
    parameter int PCWIDTH  = 8,
    parameter int INSWIDTH = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [3:0]          cfg_size,
    input  logic [PCWIDTH-1:0]  start_pc,
    output logic [PCWIDTH-1:0]  pc,
    input  logic [INSWIDTH-1:0] ins_in,
    output logic [INSWIDTH-1:0] ins_out,
    output logic [PCWIDTH-1:0]  ins_pc,
    output logic                ins_valid,
    input  logic                ins_ready,
    input  logic                redirect_valid,
    input  logic [PCWIDTH-1:0]  redirect_pc,
    output logic                busy,
    output logic                done,
    output logic [7:0]          xfer_count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t     state;
    logic [3:0] size_q;
    logic       xfer;
    logic       slot_free;
    logic       in_range;

    assign xfer      = ins_valid & ins_ready;
    assign slot_free = !ins_valid || xfer;
    // Compare at a common width so narrow PCs still see the full size.
    assign in_range  = 32'(pc) < 32'(size_q);
    assign busy      = (state == S_RUN) || (state == S_DRAIN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            size_q     <= '0;
            pc         <= '0;
            ins_out    <= '0;
            ins_pc     <= '0;
            ins_valid  <= 1'b0;
            done       <= 1'b0;
            xfer_count <= '0;
        end else begin
            done <= 1'b0;
            if (xfer && xfer_count != 8'hFF)
                xfer_count <= xfer_count + 8'd1;

            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        size_q     <= cfg_size;
                        pc         <= start_pc;
                        xfer_count <= '0;
                        if (cfg_size == 4'd0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (redirect_valid) begin
                        ins_valid <= 1'b0;
                        pc        <= redirect_pc;
                    end else if (in_range) begin
                        if (slot_free) begin
                            ins_out   <= ins_in;
                            ins_pc    <= pc;
                            ins_valid <= 1'b1;
                            pc        <= pc + PCWIDTH'(1);
                        end
                    end else begin
                        if (xfer)
                            ins_valid <= 1'b0;
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (redirect_valid) begin
                        ins_valid <= 1'b0;
                        pc        <= redirect_pc;
                        state     <= S_RUN;
                    end else if (!ins_valid) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (xfer) begin
                        ins_valid <= 1'b0;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
